// File: rtl/ysyx_22050550_mdu.sv
// ysyx_22050550_mdu: iterative RISC-V M-extension multiply/divide unit, STEP bits per cycle.
// Define YSYX_22050550_MDU_FASTPATH_EN to finish x/0, MIN/-1 and x*0 immediately after acceptance.
module ysyx_22050550_mdu #(
  parameter int XLEN = 64,
  parameter int STEP = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [2:0]      io_in_op,
  input  logic            io_in_word,
  input  logic [XLEN-1:0] io_in_src1,
  input  logic [XLEN-1:0] io_in_src2,
  input  logic            io_flush,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_result
);
  localparam int CW = $clog2(XLEN / STEP + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d, mc_q, mc_d, prod;
  logic [XLEN-1:0]   mr_q, mr_d, rem_q, rem_d, quo_q, quo_d, dvs_q, res_q, res_d;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b, quot, remd, raw;
  logic [XLEN:0]     t;
  logic [2:0]        op_q;
  logic              wd_q, sgn_q, rneg_q, dz_q;
  logic              wd, s1, s2, neg_a, neg_b, dz, fire, fast;

  function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] x, input logic w);
    return w ? XLEN'($signed(x[31:0])) : x;
  endfunction

  assign wd    = io_in_word && (XLEN == 64);
  assign s1    = io_in_op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
  assign s2    = io_in_op inside {3'd0, 3'd1, 3'd4, 3'd6};
  assign a_ext = wd ? (s1 ? XLEN'($signed(io_in_src1[31:0])) : XLEN'(io_in_src1[31:0])) : io_in_src1;
  assign b_ext = wd ? (s2 ? XLEN'($signed(io_in_src2[31:0])) : XLEN'(io_in_src2[31:0])) : io_in_src2;
  assign neg_a = s1 && a_ext[XLEN-1];
  assign neg_b = s2 && b_ext[XLEN-1];
  assign mag_a = neg_a ? -a_ext : a_ext;
  assign mag_b = neg_b ? -b_ext : b_ext;
  assign dz    = b_ext == '0;

  assign io_in_ready   = !io_flush && (state_q == IDLE || (state_q == DONE && io_out_ready));
  assign fire          = io_in_valid && io_in_ready;
  assign io_out_valid  = state_q == DONE;
  assign io_out_result = res_q;

`ifdef YSYX_22050550_MDU_FASTPATH_EN
  logic [XLEN-1:0] lim, fres;
  logic            ov;
  assign lim  = wd ? XLEN'(1) << 31 : XLEN'(1) << (XLEN - 1);
  assign ov   = io_in_op[2] && !io_in_op[0] && neg_a && mag_a == lim && b_ext == '1;
  assign fast = io_in_op[2] ? (dz || ov) : (a_ext == '0 || b_ext == '0);
  assign fres = fin(io_in_op[2] ? (io_in_op[1] ? (dz ? a_ext : '0) : (dz ? '1 : a_ext)) : '0, wd);
`else
  assign fast = 1'b0;
`endif

  // Both datapaths advance every cycle; op_q picks which one feeds the result.
  always_comb begin
    acc_d = acc_q;
    mc_d  = mc_q;
    mr_d  = mr_q;
    rem_d = rem_q;
    quo_d = quo_q;
    t     = '0;
    for (int i = 0; i < STEP; i++) begin
      acc_d = mr_d[0] ? acc_d + mc_d : acc_d;
      mc_d  = mc_d << 1;
      mr_d  = mr_d >> 1;
      t     = {rem_d, quo_d[XLEN-1]};
      quo_d = {quo_d[XLEN-2:0], t >= {1'b0, dvs_q}};
      rem_d = t >= {1'b0, dvs_q} ? XLEN'(t - {1'b0, dvs_q}) : t[XLEN-1:0];
    end
  end

  assign prod  = sgn_q ? -acc_d : acc_d;
  assign quot  = dz_q ? '1 : (sgn_q ? -quo_d : quo_d);
  assign remd  = rneg_q ? -rem_d : rem_d;
  assign raw   = op_q[2] ? (op_q[1] ? remd : quot)
                         : ((op_q == 3'd0 || wd_q) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign res_d = fin(raw, wd_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mr_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      wd_q    <= 1'b0;
      sgn_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else if (io_flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (fire) begin
      state_q <= fast ? DONE : BUSY;
      cnt_q   <= wd ? CW'(32 / STEP) : CW'(XLEN / STEP);
      op_q    <= io_in_op;
      wd_q    <= wd;
      sgn_q   <= neg_a ^ neg_b;
      rneg_q  <= neg_a;
      dz_q    <= dz;
      acc_q   <= '0;
      mc_q    <= {{XLEN{1'b0}}, mag_a};
      mr_q    <= mag_b;
      dvs_q   <= mag_b;
      rem_q   <= '0;
      quo_q   <= wd ? mag_a << (XLEN - 32) : mag_a;
`ifdef YSYX_22050550_MDU_FASTPATH_EN
      if (fast) res_q <= fres;
`endif
    end else if (state_q == BUSY) begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mr_q  <= mr_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_q <= DONE;
        res_q   <= res_d;
      end
    end else if (state_q == DONE && io_out_ready) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: doc/ysyx_22050550_mdu.md
YSYX_22050550_MDU -- requirements
Module: ysyx_22050550_mdu

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 32 or 64.
REQ-002 Parameter STEP, default 1, quotient/multiplier bits retired per iteration; legal values 1, 2, 4.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_in_valid  input  1  request valid.
REQ-006 io_in_ready  output  1  request accepted when valid and ready are both high at a rising edge.
REQ-007 io_in_op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 io_in_word  input  1  32-bit word variant (MULW/DIVW/DIVUW/REMW/REMUW).
REQ-009 io_in_src1 / io_in_src2  input  XLEN each  operand 1 / operand 2.
REQ-010 io_flush  input  1  synchronous abort of any request in flight.
REQ-011 io_out_valid  output  1  result valid.
REQ-012 io_out_ready  input  1  consumer accepts result.
REQ-013 io_out_result  output  XLEN  result.

Function
REQ-014 States: IDLE, BUSY, DONE; operands, op, word and iteration counter are latched on acceptance.
REQ-015 io_in_ready is high in IDLE, and in DONE when io_out_ready is high; it is low whenever io_flush is high.
REQ-016 Acceptance moves to BUSY; BUSY performs N = W/STEP iterations (W = 32 if word, else XLEN); the Nth iteration edge moves to DONE.
REQ-017 Latency: io_out_valid rises exactly N cycles after the acceptance edge.
REQ-018 io_out_valid is high only in DONE; io_out_result holds stable while io_out_valid is high and io_out_ready is low.
REQ-019 DONE with io_out_ready: no new request -> IDLE; new request accepted in the same cycle -> BUSY with no bubble.
REQ-020 io_flush: next state IDLE from any state, no result emitted; flush wins over a same-cycle acceptance.
REQ-021 Multiply: iterative shift-add on magnitudes with final sign correction; MUL returns the low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits of the 2*XLEN product with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-022 Divide: iterative restoring division on magnitudes; the quotient sign is the XOR of the operand signs and the remainder takes the dividend's sign (truncating division).
REQ-023 Divide by zero: quotient all ones, remainder = dividend.
REQ-024 Signed overflow (most-negative / -1): quotient = dividend, remainder 0.
REQ-025 Word mode: operands taken from bits [31:0], sign- or zero-extended per op; result bits [31:0] are sign-extended to XLEN; word with MULH/MULHSU/MULHU behaves as MUL word; word is ignored when XLEN=32.
REQ-026 Operand changes on io_in_* after acceptance do not affect the in-flight result.

Reset
REQ-027 While reset is low: state IDLE, counter 0, io_out_valid 0, io_out_result 0, io_in_ready 1 (unless io_flush is high).
REQ-028 Reset asserted mid-operation discards the request immediately and asynchronously; no result appears after release.

Configuration
REQ-029 Macro YSYX_22050550_MDU_FASTPATH_EN defined: divide by zero, signed overflow, and multiply with either operand 0 skip BUSY and go IDLE->DONE, with io_out_valid one cycle after acceptance.
REQ-030 Macro undefined: the same cases take the full N-cycle latency; result values are identical in both builds.

Verification
REQ-031 XLEN=64, STEP=1: MUL 7 x -3 -> after 64 cycles result 0xFFFFFFFFFFFFFFEB; MULHU 0xFFFFFFFFFFFFFFFF x 2 -> 0x1.
REQ-032 DIV -7 / 2 -> 0xFFFFFFFFFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFFFFFFFFFF; DIVU 100 / 0 -> all ones; REM 0x8000000000000000 / -1 -> 0; with FASTPATH, the last two complete in 1 cycle, otherwise in 64.
REQ-033 DIVW 0x00000000_80000000 / 0xFFFFFFFF_FFFFFFFF -> 0xFFFFFFFF80000000 after 32 cycles (STEP=1) or 8 cycles (STEP=4).
REQ-034 Hold io_out_ready low 5 cycles in DONE -> result stable, io_in_ready low; raise io_out_ready with io_in_valid high -> new request accepted in that cycle, next result N cycles later.
REQ-035 Assert io_flush in BUSY at iteration 10 -> IDLE next cycle, no io_out_valid; flush together with io_in_valid in IDLE -> no acceptance.
REQ-036 Drop reset mid-BUSY -> io_out_valid 0 and state IDLE without waiting for a clock edge; the first request after release returns its correct result.
